chunked_adder: RTL and testbench

Parametrised multi-cycle adder, the sequential successor to the team's 4-bit ripple-carry adder. It adds two WIDTH-bit operands plus a carry-in over WIDTH/CHUNK clock cycles, processing one CHUNK-bit slice per cycle with a registered inter-chunk carry. Operands enter and results leave through valid/ready handshakes, so the block drops into datapaths where a single-cycle WIDTH-bit carry chain would not meet timing.

---
 rtl/chunked_adder.sv | 113 +++++++++++
 tb/tb_chunked_adder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// chunked_adder: WIDTH-bit adder that adds CHUNK bits per clock with a registered inter-chunk carry.
// Define CHUNKED_ADDER_ADDSUB_EN to add the sub port (a - b through inverted B and inverted carry-in).
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic sub_eff;
`ifdef CHUNKED_ADDER_ADDSUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Handshakes: a transfer happens on an edge where valid && ready; in_ready and
    // out_valid come from state only, and out_valid holds with stable results until taken.
    logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
    logic             carry_r;
    logic [KW-1:0]    k;
    logic [CHUNK:0]   slice_sum;
    logic             msb_cin;
    logic             last;

    // Operand registers shift right each RUN cycle, so the current slice is always the low CHUNK bits.
    always_comb begin
        slice_sum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_r};
        acc_nxt   = (acc >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        msb_cin   = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ slice_sum[CHUNK-1];
        last      = (k == K_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            carry_r <= 1'b0;
            k       <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b ^ {WIDTH{sub_eff}};
                        carry_r <= cin ^ sub_eff;
                        k       <= '0;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> CHUNK;
                    b_r     <= b_r >> CHUNK;
                    acc     <= acc_nxt;
                    carry_r <= slice_sum[CHUNK];
                    k       <= k + 1'b1;
                    if (last) begin
                        sum  <= acc_nxt;
                        cout <= slice_sum[CHUNK];
                        ovf  <= msb_cin ^ slice_sum[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (WIDTH=16, CHUNK=4, plus a CHUNK=16 instance).
// Exercises the sub port when built with CHUNKED_ADDER_ADDSUB_EN.
module tb_chunked_adder;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;
`ifdef CHUNKED_ADDER_ADDSUB_EN
    localparam bit ADDSUB = 1'b1;
`else
    localparam bit ADDSUB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] a, b, sum;
    logic             cin, sub, cout, ovf;

    logic             one_in_valid, one_in_ready, one_out_valid, one_out_ready;
    logic [WIDTH-1:0] one_a, one_b, one_sum;
    logic             one_cin, one_sub, one_cout, one_ovf;

    int checks = 0;
    int errors = 0;
    logic [WIDTH+1:0] exp_q[$];

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_ADDER_ADDSUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(WIDTH)) u_one (
        .clk(clk), .rst(rst), .in_valid(one_in_valid), .in_ready(one_in_ready),
        .a(one_a), .b(one_b), .cin(one_cin),
`ifdef CHUNKED_ADDER_ADDSUB_EN
        .sub(one_sub),
`endif
        .out_valid(one_out_valid), .out_ready(one_out_ready),
        .sum(one_sum), .cout(one_cout), .ovf(one_ovf)
    );

    // Reference: whole-word arithmetic, returns {ovf, cout, sum}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
        logic [WIDTH-1:0] ye;
        logic             ce;
        logic [WIDTH:0]   t;
        logic             ov;
        ye = s ? ~y : y;
        ce = c ^ s;
        t  = {1'b0, x} + {1'b0, ye} + {{WIDTH{1'b0}}, ce};
        ov = (x[WIDTH-1] == ye[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return {ov, t[WIDTH], t[WIDTH-1:0]};
    endfunction

    // Driver: offer one operand set at the IDLE block, return cycles until out_valid.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                          input logic tc, input logic ts, output int lat, output logic ready_leak);
        int w;
        w = 0;
        lat = 0;
        ready_leak = 1'b0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_leak = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({ovf, cout, sum} !== 18'h0) begin errors++; $display("FAIL reset_outputs: got ovf=%b cout=%b sum=%h expected all 0", ovf, cout, sum); end
        checks++; if (one_in_ready !== 1'b1 || one_out_valid !== 1'b0) begin errors++; $display("FAIL reset_one: got in_ready=%b out_valid=%b expected 1/0", one_in_ready, one_out_valid); end
    endtask

    task automatic test_unsigned_wrap();
        int lat;
        logic leak;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, leak);
        checks++; if (lat !== NCH) begin errors++; $display("FAIL wrap_latency: got %0d expected %0d", lat, NCH); end
        checks++; if ({ovf, cout, sum} !== {1'b0, 1'b1, 16'h0000}) begin errors++; $display("FAIL wrap_result: got ovf=%b cout=%b sum=%h expected 0/1/0000", ovf, cout, sum); end
        checks++; if (leak !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL wrap_in_ready: got run_leak=%b done_in_ready=%b expected 0/0", leak, in_ready); end
        release_out();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_signed_ovf();
        int lat;
        logic leak;
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, lat, leak);
        checks++; if ({ovf, cout, sum} !== {1'b1, 1'b0, 16'h8000}) begin errors++; $display("FAIL signed_ovf: got ovf=%b cout=%b sum=%h expected 1/0/8000", ovf, cout, sum); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic leak;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, leak);
        checks++; if (sum !== 16'h2345) begin errors++; $display("FAIL bp_sum: got %h expected 2345", sum); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || sum !== 16'h2345 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got out_valid=%b sum=%h in_ready=%b expected 1/2345/0", i, out_valid, sum, in_ready);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h2345) begin errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b sum=%h expected 0/1/2345", out_valid, in_ready, sum); end
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, lat, leak);
        checks++; if (sum !== 16'h1010) begin errors++; $display("FAIL bp_next: got %h expected 1010", sum); end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic leak;
        while (!in_ready) @(negedge clk);
        a = 16'hABCD; b = 16'h1357; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_state: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        checks++; if ({ovf, cout, sum} !== 18'h0) begin errors++; $display("FAIL midrst_outputs: got ovf=%b cout=%b sum=%h expected all 0", ovf, cout, sum); end
        repeat (NCH + 1) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard: got out_valid=%b expected 0", out_valid); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat, leak);
        checks++; if (sum !== 16'h0002) begin errors++; $display("FAIL midrst_after: got %h expected 0002", sum); end
        release_out();
    endtask

    task automatic test_addsub();
`ifdef CHUNKED_ADDER_ADDSUB_EN
        int lat;
        logic leak;
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat, leak);
        checks++; if ({ovf, cout, sum} !== {1'b0, 1'b0, 16'hFFFE}) begin errors++; $display("FAIL sub_5_7: got ovf=%b cout=%b sum=%h expected 0/0/FFFE", ovf, cout, sum); end
        release_out();
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, leak);
        checks++; if ({ovf, cout, sum} !== {1'b1, 1'b1, 16'h7FFF}) begin errors++; $display("FAIL sub_ovf: got ovf=%b cout=%b sum=%h expected 1/1/7FFF", ovf, cout, sum); end
        release_out();
`endif
    endtask

    task automatic test_random();
        int lat;
        logic leak;
        logic [WIDTH-1:0] ra, rb;
        logic rc, rs;
        logic [WIDTH+1:0] exp;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = ADDSUB ? 1'($urandom_range(0, 1)) : 1'b0;
            exp = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, lat, leak);
            checks++;
            if ({ovf, cout, sum} !== exp || lat !== NCH) begin
                errors++;
                $display("FAIL random[%0d]: a=%h b=%h cin=%b sub=%b got %h lat %0d expected %h lat %0d", i, ra, rb, rc, rs, {ovf, cout, sum}, lat, exp, NCH);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++; if (out_valid !== 1'b1 || {ovf, cout, sum} !== exp) begin errors++; $display("FAIL random_hold[%0d]: got out_valid=%b result=%h expected 1/%h", i, out_valid, {ovf, cout, sum}, exp); end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        int last_out;
        logic [WIDTH+1:0] exp;
        last_out = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            in_valid = (cyc < 70);
            a = 16'($urandom);
            b = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = ADDSUB ? 1'($urandom_range(0, 1)) : 1'b0;
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got result %h with empty queue", {ovf, cout, sum});
                end else begin
                    exp = exp_q.pop_front();
                    if ({ovf, cout, sum} !== exp) begin
                        errors++;
                        $display("FAIL b2b_result: got %h expected %h", {ovf, cout, sum}, exp);
                    end
                end
                if (last_out >= 0) begin
                    checks++;
                    if (cyc - last_out !== NCH + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last_out, NCH + 2); end
                end
                last_out = cyc;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (exp_q.size() != 0 || last_out < 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, last_out %0d expected 0 pending", exp_q.size(), last_out); end
    endtask

    task automatic test_single_chunk();
        int lat;
        logic [WIDTH+1:0] exp;
        for (int i = 0; i < 4; i++) begin
            one_a = (i == 0) ? 16'hFFFF : 16'($urandom);
            one_b = (i == 0) ? 16'hFFFF : 16'($urandom);
            one_cin = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            exp = model(one_a, one_b, one_cin, 1'b0);
            one_in_valid = 1'b1;
            @(negedge clk);
            one_in_valid = 1'b0;
            lat = 0;
            while (!one_out_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat !== 1) begin errors++; $display("FAIL one_latency[%0d]: got %0d expected 1", i, lat); end
            checks++; if ({one_ovf, one_cout, one_sum} !== exp) begin errors++; $display("FAIL one_result[%0d]: got %h expected %h", i, {one_ovf, one_cout, one_sum}, exp); end
            one_out_ready = 1'b1;
            @(negedge clk);
            one_out_ready = 1'b0;
            checks++; if (one_in_ready !== 1'b1) begin errors++; $display("FAIL one_release[%0d]: got in_ready=%b expected 1", i, one_in_ready); end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        one_in_valid = 1'b0; one_out_ready = 1'b0; one_a = '0; one_b = '0; one_cin = 1'b0; one_sub = 1'b0;
        test_reset();
        test_unsigned_wrap();
        test_signed_ovf();
        test_backpressure();
        test_reset_mid_run();
        test_addsub();
        test_random();
        test_back_to_back();
        test_single_chunk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
